video: RTL and testbench



---
 rtl/video.sv | 132 +++++++++++++
 tb/tb_video.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video.sv
// Text-mode video generator: raster timing, VRAM/char-ROM fetch and 1-bit pixel serializer.
// Optional build macro VIDEO_REVERSE_EN: character code bit 7 inverts the glyph row.
module video #(
  parameter int H_TOTAL      = 64,
  parameter int H_DISPLAYED  = 40,
  parameter int H_SYNC_POS   = 48,
  parameter int H_SYNC_WIDTH = 4,
  parameter int V_TOTAL      = 260,
  parameter int V_DISPLAYED  = 200,
  parameter int V_SYNC_POS   = 224,
  parameter int V_SYNC_WIDTH = 10
) (
  input  logic        sys_clock_i,
  input  logic        reset_n_i,
  input  logic        pixel_ce_i,
  input  logic        gfx_i,
  output logic [9:0]  vram_addr_o,
  input  logic [7:0]  vram_data_i,
  output logic [10:0] crom_addr_o,
  input  logic [7:0]  crom_data_i,
  output logic        video_o,
  output logic        de_o,
  output logic        h_sync_o,
  output logic        v_sync_o
);

  localparam int CW = $clog2(H_TOTAL);
  localparam int LW = $clog2(V_TOTAL);

  // Bounds are one bit wider than the counters so a range ending at the total cannot wrap.
  localparam logic [CW:0]   H_DISP_X = (CW+1)'(H_DISPLAYED);
  localparam logic [CW:0]   H_SYNC_LO = (CW+1)'(H_SYNC_POS);
  localparam logic [CW:0]   H_SYNC_HI = (CW+1)'(H_SYNC_POS + H_SYNC_WIDTH);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [LW:0]   V_DISP_X = (LW+1)'(V_DISPLAYED);
  localparam logic [LW:0]   V_SYNC_LO = (LW+1)'(V_SYNC_POS);
  localparam logic [LW:0]   V_SYNC_HI = (LW+1)'(V_SYNC_POS + V_SYNC_WIDTH);
  localparam logic [LW-1:0] V_LAST = LW'(V_TOTAL - 1);
  localparam logic [9:0]    ROW_STEP = 10'(H_DISPLAYED);

`ifdef VIDEO_REVERSE_EN
  localparam logic REVERSE = 1'b1;
`else
  localparam logic REVERSE = 1'b0;
`endif

  logic [2:0]    r_p;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic [9:0]    r_row_start;
  logic          r_rev;
  logic [7:0]    r_glyph;
  logic [7:0]    r_shift;
  logic          r_de;
  logic          r_hs;
  logic          r_vs;

  logic [CW:0]   w_col_x;
  logic [LW:0]   w_line_x;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic [9:0]    w_ma;
  logic [7:0]    w_glyph;

  assign w_col_x  = {1'b0, r_col};
  assign w_line_x = {1'b0, r_line};
  assign w_active = (w_col_x < H_DISP_X) && (w_line_x < V_DISP_X);
  assign w_hs     = (w_col_x >= H_SYNC_LO) && (w_col_x < H_SYNC_HI);
  assign w_vs     = (w_line_x >= V_SYNC_LO) && (w_line_x < V_SYNC_HI);
  assign w_ma     = r_row_start + 10'(r_col);
  assign w_glyph  = (REVERSE && r_rev) ? ~r_glyph : r_glyph;

  always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_p         <= '0;
      r_col       <= '0;
      r_line      <= '0;
      r_row_start <= '0;
      r_rev       <= 1'b0;
      r_glyph     <= '0;
      r_shift     <= '0;
      r_de        <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      vram_addr_o <= '0;
      crom_addr_o <= '0;
    end else if (pixel_ce_i) begin
      r_p <= r_p + 3'd1;
      if (r_p == 3'd7) begin
        // Slot boundary: advance raster and hand the fetched slot to the serializer.
        if (r_col == H_LAST) begin
          r_col <= '0;
          if (r_line == V_LAST) begin
            r_line      <= '0;
            r_row_start <= '0;
          end else begin
            r_line <= r_line + LW'(1);
            if (r_line[2:0] == 3'd7)
              r_row_start <= r_row_start + ROW_STEP;
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
        r_shift <= w_active ? w_glyph : 8'h00;
        r_de    <= w_active;
        r_hs    <= w_hs;
        r_vs    <= w_vs;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end

      if (w_active) begin
        case (r_p)
          3'd1: vram_addr_o <= w_ma;
          3'd3: begin
            crom_addr_o <= {gfx_i, vram_data_i[6:0], r_line[2:0]};
            r_rev       <= vram_data_i[7];
          end
          3'd5: r_glyph <= crom_data_i;
          default: ;
        endcase
      end
    end
  end

  assign video_o  = r_shift[7];
  assign de_o     = r_de;
  assign h_sync_o = r_hs;
  assign v_sync_o = r_vs;

endmodule

// File: tb/tb_video.sv
// Self-checking bench for video: scaled raster, synchronous memory models, slot-level reference model.
module tb_video;

  localparam int HT = 16, HD = 10, HSP = 12, HSW = 2;
  localparam int VT = 40, VD = 24, VSP = 30, VSW = 3;
  localparam int FRAME = HT * VT * 8;
  localparam int REC_N = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pixel_ce = 1'b0;
  logic        gfx = 1'b0;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data = 8'h00;
  logic [10:0] crom_addr;
  logic [7:0]  crom_data = 8'h00;
  logic        video_out, de, hs, vs;

  logic [7:0]  vmem [1024];
  logic [7:0]  cmem [2048];
  logic [24:0] rec  [REC_N];

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic       e_video, e_de, e_hs, e_vs;
  logic [9:0] e_vaddr;
  logic [10:0] e_caddr;
  logic [24:0] got, exp_v;

  video #(
    .H_TOTAL(HT), .H_DISPLAYED(HD), .H_SYNC_POS(HSP), .H_SYNC_WIDTH(HSW),
    .V_TOTAL(VT), .V_DISPLAYED(VD), .V_SYNC_POS(VSP), .V_SYNC_WIDTH(VSW)
  ) dut (
    .sys_clock_i(clk),
    .reset_n_i(reset_n),
    .pixel_ce_i(pixel_ce),
    .gfx_i(gfx),
    .vram_addr_o(vram_addr),
    .vram_data_i(vram_data),
    .crom_addr_o(crom_addr),
    .crom_data_i(crom_data),
    .video_o(video_out),
    .de_o(de),
    .h_sync_o(hs),
    .v_sync_o(vs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_data <= vmem[vram_addr];
    crom_data <= cmem[crom_addr];
  end

  assign got = {video_out, de, hs, vs, vram_addr, crom_addr};

  // Outputs seen before the n-th pixel_ce describe the previous slot (one-slot pipeline).
  task automatic model_expect(input int idx);
    int s, p, col, line, ma;
    logic [7:0] code, g;
    logic [2:0] ra;
    e_video = 1'b0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
    s = idx / 8;
    p = idx % 8;
    if (s > 0) begin
      col  = (s - 1) % HT;
      line = ((s - 1) / HT) % VT;
      e_hs = (col >= HSP) && (col < HSP + HSW);
      e_vs = (line >= VSP) && (line < VSP + VSW);
      if (col < HD && line < VD) begin
        e_de = 1'b1;
        ma   = ((line / 8) * HD + col) % 1024;
        code = vmem[ma];
        ra   = 3'(line % 8);
        g    = cmem[{gfx, code[6:0], ra}];
`ifdef VIDEO_REVERSE_EN
        if (code[7]) g = ~g;
`endif
        e_video = g[7 - p];
      end
    end
    exp_v = {e_video, e_de, e_hs, e_vs, e_vaddr, e_caddr};
  endtask

  // Address outputs after the n-th pixel_ce.
  task automatic model_advance(input int idx);
    int s, p, col, line, ma;
    logic [7:0] code;
    logic [2:0] ra;
    s = idx / 8;
    p = idx % 8;
    col  = s % HT;
    line = (s / HT) % VT;
    if (col < HD && line < VD) begin
      ma = ((line / 8) * HD + col) % 1024;
      ra = 3'(line % 8);
      if (p == 1) e_vaddr = 10'(ma);
      if (p == 3) begin
        code = vmem[ma];
        e_caddr = {gfx, code[6:0], ra};
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    pixel_ce = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    e_vaddr = '0;
    e_caddr = '0;
  endtask

  task automatic pulse_ce(input int gap);
    pixel_ce = 1'b1;
    @(negedge clk);
    pixel_ce = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pixel_ce = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (got !== 25'd0) begin
      errors++;
      $display("FAIL reset_state: got=%h required=%h", got, 25'd0);
    end
    $display("reset_state outputs=%h", got);
    do_reset();
  endtask

  task automatic test_pattern();
    int bad = 0;
    for (int a = 0; a < 1024; a++) vmem[a] = 8'(a);
    for (int a = 0; a < 2048; a++) cmem[a] = 8'hAA;
    gfx = 1'b0;
    do_reset();
    for (int i = 0; i < HT * 8 * 18; i++) begin
      model_expect(n);
      checks++;
      if (got !== exp_v) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL pattern n=%0d: got=%h required=%h", n, got, exp_v);
      end
      model_advance(n);
      pulse_ce(0);
      n++;
    end
    $display("pattern ces=%0d last_vram_addr=%0d", n, vram_addr);
  endtask

  task automatic test_crom_addr();
    for (int a = 0; a < 1024; a++) vmem[a] = 8'($urandom);
    for (int a = 0; a < 2048; a++) cmem[a] = 8'($urandom);
    vmem[5] = 8'h41;
    gfx = 1'b1;
    do_reset();
    while (n < (3 * HT + 5) * 8 + 4) begin
      model_expect(n);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL crom_walk n=%0d: got=%h required=%h", n, got, exp_v);
      end
      model_advance(n);
      pulse_ce(0);
      n++;
    end
    checks++;
    if (crom_addr !== 11'h60B) begin
      errors++;
      $display("FAIL crom_addr: got=%h required=%h", crom_addr, 11'h60B);
    end
    $display("crom_addr line3 col5 = %h", crom_addr);
  endtask

  task automatic test_reverse();
    logic [7:0] seen, want;
    seen = 8'h00;
`ifdef VIDEO_REVERSE_EN
    want = 8'h0F;
`else
    want = 8'hF0;
`endif
    vmem[0] = 8'h81;
    cmem[11'h008] = 8'hF0;
    gfx = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (n >= 8) seen = {seen[6:0], video_out};
      pulse_ce(0);
      n++;
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL reverse: got=%b required=%b", seen, want);
    end
    $display("reverse pixels=%b", seen);
  endtask

  task automatic test_frame();
    int bad = 0, hs_edges = 0, hs_cnt = 0, vs_edges = 0, vs_cnt = 0, de_cnt = 0;
    logic hs_prev = 1'b0, vs_prev = 1'b0;
    for (int a = 0; a < 1024; a++) vmem[a] = 8'($urandom);
    for (int a = 0; a < 2048; a++) cmem[a] = 8'($urandom);
    gfx = 1'($urandom_range(0, 1));
    do_reset();
    for (int i = 0; i < FRAME + 3 * HT * 8; i++) begin
      model_expect(n);
      checks++;
      if (got !== exp_v) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL frame n=%0d: got=%h required=%h", n, got, exp_v);
      end
      if (n < REC_N) rec[n] = got;
      if (n < FRAME) begin
        if (hs && !hs_prev) hs_edges++;
        if (vs && !vs_prev) vs_edges++;
        hs_cnt += int'(hs);
        vs_cnt += int'(vs);
        de_cnt += int'(de);
      end
      hs_prev = hs;
      vs_prev = vs;
      model_advance(n);
      pulse_ce(0);
      n++;
    end
    checks++;
    if (hs_edges != VT || hs_cnt != VT * HSW * 8) begin
      errors++;
      $display("FAIL hsync_count: got pulses=%0d ces=%0d required %0d/%0d", hs_edges, hs_cnt, VT, VT * HSW * 8);
    end
    checks++;
    if (vs_edges != 1 || vs_cnt != VSW * HT * 8) begin
      errors++;
      $display("FAIL vsync_count: got pulses=%0d ces=%0d required 1/%0d", vs_edges, vs_cnt, VSW * HT * 8);
    end
    checks++;
    if (de_cnt != HD * 8 * VD) begin
      errors++;
      $display("FAIL de_count: got=%0d required=%0d", de_cnt, HD * 8 * VD);
    end
    $display("frame hs=%0d vs=%0d de=%0d", hs_edges, vs_edges, de_cnt);
  endtask

  task automatic test_ce_rate();
    int bad = 0;
    logic [24:0] after;
    do_reset();
    for (int i = 0; i < REC_N; i++) begin
      checks++;
      if (got !== rec[n]) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL ce_rate n=%0d: got=%h required=%h", n, got, rec[n]);
      end
      pixel_ce = 1'b1;
      @(negedge clk);
      pixel_ce = 1'b0;
      after = got;
      repeat (2) @(negedge clk);
      checks++;
      if (got !== after) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL ce_hold n=%0d: got=%h required=%h", n, got, after);
      end
      n++;
    end
    $display("ce_rate ces=%0d compared", n);
  endtask

  task automatic test_reset_mid();
    do_reset();
    while (n < (20 * HT + 5) * 8 + 3) begin
      model_expect(n);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL mid_walk n=%0d: got=%h required=%h", n, got, exp_v);
      end
      model_advance(n);
      pulse_ce(0);
      n++;
    end
    pixel_ce = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (got !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset: got=%h required=%h", got, 25'd0);
    end
    @(negedge clk);
    pixel_ce = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    e_vaddr = '0;
    e_caddr = '0;
    for (int i = 0; i < HT * 8 + 16; i++) begin
      model_expect(n);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL after_reset n=%0d: got=%h required=%h", n, got, exp_v);
      end
      model_advance(n);
      pulse_ce(0);
      n++;
      if (n == 2) begin
        checks++;
        if (vram_addr !== 10'd0) begin
          errors++;
          $display("FAIL first_fetch: got=%0d required=0", vram_addr);
        end
      end
    end
    $display("reset_mid ces_after_release=%0d", n);
  endtask

  initial begin
    e_vaddr = '0;
    e_caddr = '0;
    for (int a = 0; a < 1024; a++) vmem[a] = 8'h00;
    for (int a = 0; a < 2048; a++) cmem[a] = 8'h00;
    test_reset();
    test_pattern();
    test_crom_addr();
    test_reverse();
    test_frame();
    test_ce_rate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
